// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-of-day clock with set mode.
//   clock_state_t : operating state (RUN, SET_HOUR, SET_MIN)
//   HOUR_MAX      : last legal hour value, two BCD digits (23)
//   MIN_MAX       : last legal minute value, two BCD digits (59)
//   SEC_MAX       : last legal second value, two BCD digits (59)
//   bcd2_inc()    : non-wrapping increment of a two-digit BCD value
// -----------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } clock_state_t;

   localparam logic [7:0] HOUR_MAX = 8'h23;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] SEC_MAX  = 8'h59;

   // Units digit rolls 9 -> 0 with carry into tens. Field wrap is decided by
   // the caller on the full two-digit value, so this never sees 99.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_counter2.sv
// -----------------------------------------------------------------------------
// bcd_counter2
// Two-digit BCD counter, counting 00..MAX_VAL and wrapping to 00.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset, value -> 00
//   inc   in   advance by one (wraps MAX_VAL -> 00)
//   clr   in   force value to 00; wins over inc
//   value out  registered two-digit BCD value
//   carry out  combinational, high in the cycle inc wraps the counter, so a
//              chain of counters resolves all carries on a single edge
// -----------------------------------------------------------------------------
module bcd_counter2
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX_VAL = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   logic [7:0] r_value;
   logic       w_at_max;

   assign w_at_max = (r_value == MAX_VAL);
   assign carry    = inc & ~clr & w_at_max;
   assign value    = r_value;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= 8'h00;
      end else if (clr) begin
         r_value <= 8'h00;
      end else if (inc) begin
         r_value <= w_at_max ? 8'h00 : bcd2_inc(r_value);
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// 24-hour BCD time-of-day clock with a MODE/UP set mode and a blink qualifier
// for the display driver.
// Parameters:
//   TICKS_PER_SEC  clk cycles per second (prescaler modulus)
//   BLINK_HALF     clk cycles per blink half-period
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   mode_pushed  in   one-cycle MODE pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//   up_pushed    in   one-cycle UP pulse: edits the selected field in set mode
//   hour_bcd     out  hours 00..23, BCD
//   min_bcd      out  minutes 00..59, BCD
//   sec_bcd      out  seconds 00..59, BCD
//   set_hour     out  high in SET_HOUR
//   set_min      out  high in SET_MIN
//   blink_on     out  high during the visible half of the blink period
//   state_dbg    out  current FSM state (clock_state_t encoding)
//
// Input pulse semantics: mode_pushed and up_pushed carry no handshake; each
// is a single-cycle event sampled on the rising edge, acted on at that edge
// and visible on the outputs right after it. Pulses on consecutive cycles
// are each honoured. When both arrive together the mode change is taken and
// the UP pulse is discarded.
// -----------------------------------------------------------------------------
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int BLINK_HALF    = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_pushed,
   input  logic       up_pushed,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       set_hour,
   output logic       set_min,
   output logic       blink_on,
   output logic [1:0] state_dbg
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;

   clock_state_t   r_state;
   clock_state_t   w_next_state;
   logic [PW-1:0]  r_presc;
   logic [BW-1:0]  r_blink;
   logic [BW-1:0]  w_blink_next;
   logic           r_set_hour;
   logic           r_set_min;
   logic           r_blink_on;

   logic           w_up_eff;
   logic           w_in_run;
   logic           w_sec_tick;
   logic           w_set_exit;
   logic           w_state_change;
   logic           w_sec_carry;
   logic           w_min_carry;
   logic           w_min_inc;
   logic           w_hour_inc;
   logic           w_unused_hour_carry;

   // A simultaneous MODE pulse swallows UP in both the old and new state.
   assign w_up_eff       = up_pushed & ~mode_pushed;
   assign w_in_run       = (r_state == RUN);
   assign w_sec_tick     = w_in_run & (r_presc == PW'(TICKS_PER_SEC - 1));
   assign w_set_exit     = (r_state == SET_MIN) & mode_pushed;
   assign w_state_change = (w_next_state != r_state);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (mode_pushed) begin
         case (r_state)
            RUN:      w_next_state = SET_HOUR;
            SET_HOUR: w_next_state = SET_MIN;
            SET_MIN:  w_next_state = RUN;
            default:  w_next_state = RUN;
         endcase
      end
   end

   // ---------------- prescaler ----------------
   // Counts only in RUN; held in both set states. Leaving SET_MIN restarts
   // the second from zero so the new time starts on a full second.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_set_exit) begin
         r_presc <= '0;
      end else if (w_in_run) begin
         if (w_sec_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
      end
   end

   // ---------------- blink ----------------
   // Cleared on every state change so the selected field shows at once.
   always_comb begin
      w_blink_next = '0;
      if (w_state_change) begin
         w_blink_next = '0;
      end else if (r_blink == BW'(2 * BLINK_HALF - 1)) begin
         w_blink_next = '0;
      end else begin
         w_blink_next = r_blink + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink    <= '0;
         r_blink_on <= 1'b1;
         r_set_hour <= 1'b0;
         r_set_min  <= 1'b0;
      end else begin
         r_blink    <= w_blink_next;
         r_blink_on <= (w_blink_next < BW'(BLINK_HALF));
         r_set_hour <= (w_next_state == SET_HOUR);
         r_set_min  <= (w_next_state == SET_MIN);
      end
   end

   // ---------------- carry chain ----------------
   // Carries are combinational so 23:59:59 -> 00:00:00 lands on one edge.
   // In SET_MIN a minute wrap must not reach the hours, hence the RUN gate.
   assign w_min_inc  = (w_in_run & w_sec_carry)
                     | ((r_state == SET_MIN) & w_up_eff);
   assign w_hour_inc = (w_in_run & w_min_carry)
                     | ((r_state == SET_HOUR) & w_up_eff);

   bcd_counter2 #(.MAX_VAL(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_sec_tick),
      .clr   (w_set_exit),
      .value (sec_bcd),
      .carry (w_sec_carry)
   );

   bcd_counter2 #(.MAX_VAL(MIN_MAX)) u_min (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_min_inc),
      .clr   (1'b0),
      .value (min_bcd),
      .carry (w_min_carry)
   );

   bcd_counter2 #(.MAX_VAL(HOUR_MAX)) u_hour (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_hour_inc),
      .clr   (1'b0),
      .value (hour_bcd),
      .carry (w_unused_hour_carry)
   );

   assign set_hour  = r_set_hour;
   assign set_min   = r_set_min;
   assign blink_on  = r_blink_on;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl. A full-rate instance (1000/500) covers
// reset, the first second, set-mode editing and mode/up collisions; a
// fast instance (4/2) covers the 23:59:59 rollover in a few hundred cycles.
// Expected output vectors are pushed with the cycle they belong to; a
// monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

   localparam logic [1:0] S_RUN = 2'd0;
   localparam logic [1:0] S_SH  = 2'd1;
   localparam logic [1:0] S_SM  = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s  = 1'b1;
   logic rst_f  = 1'b1;
   logic mode_s = 1'b0;
   logic up_s   = 1'b0;
   logic mode_f = 1'b0;
   logic up_f   = 1'b0;

   logic [7:0] hour_s, min_s, sec_s, hour_f, min_f, sec_f;
   logic       sh_s, sm_s, bo_s, sh_f, sm_f, bo_f;
   logic [1:0] st_s, st_f;

   clock_set_ctrl #(.TICKS_PER_SEC(1000), .BLINK_HALF(500)) dut_s (
      .clk         (clk),
      .rst         (rst_s),
      .mode_pushed (mode_s),
      .up_pushed   (up_s),
      .hour_bcd    (hour_s),
      .min_bcd     (min_s),
      .sec_bcd     (sec_s),
      .set_hour    (sh_s),
      .set_min     (sm_s),
      .blink_on    (bo_s),
      .state_dbg   (st_s)
   );

   clock_set_ctrl #(.TICKS_PER_SEC(4), .BLINK_HALF(2)) dut_f (
      .clk         (clk),
      .rst         (rst_f),
      .mode_pushed (mode_f),
      .up_pushed   (up_f),
      .hour_bcd    (hour_f),
      .min_bcd     (min_f),
      .sec_bcd     (sec_f),
      .set_hour    (sh_f),
      .set_min     (sm_f),
      .blink_on    (bo_f),
      .state_dbg   (st_f)
   );

   logic [28:0] out_s, out_f;
   assign out_s = {st_s, hour_s, min_s, sec_s, sh_s, sm_s, bo_s};
   assign out_f = {st_f, hour_f, min_f, sec_f, sh_f, sm_f, bo_f};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [28:0] exp_q[$];
   int          tgt_q[$];
   bit          sel_q[$];
   string       tag_q[$];
   int          checks  = 0;
   int          errors  = 0;
   bit          sel     = 1'b0;
   int          rel_cyc = 0;

   function automatic logic [28:0] mk(input logic [1:0] st, input logic [7:0] h,
                                      input logic [7:0] m, input logic [7:0] s,
                                      input logic sh, input logic sm, input logic bo);
      return {st, h, m, s, sh, sm, bo};
   endfunction

   always @(negedge clk) begin : monitor
      logic [28:0] act_v;
      logic [28:0] exp_v;
      string       tag;
      bit          s;
      int          tgt;
      while (tgt_q.size() > 0 && tgt_q[0] <= cyc) begin
         exp_v = exp_q.pop_front();
         tgt   = tgt_q.pop_front();
         s     = sel_q.pop_front();
         tag   = tag_q.pop_front();
         act_v = s ? out_f : out_s;
         checks++;
         if (tgt != cyc) begin
            errors++;
            $display("FAIL %s: checked at cycle %0d, required cycle %0d", tag, cyc, tgt);
         end else if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got st=%0d %h:%h:%h sh=%b sm=%b bo=%b, expected st=%0d %h:%h:%h sh=%b sm=%b bo=%b",
                     tag, act_v[28:27], act_v[26:19], act_v[18:11], act_v[10:3],
                     act_v[2], act_v[1], act_v[0],
                     exp_v[28:27], exp_v[26:19], exp_v[18:11], exp_v[10:3],
                     exp_v[2], exp_v[1], exp_v[0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic m, input logic u);
      @(negedge clk);
      if (!sel) begin
         mode_s = m;  up_s = u;  mode_f = 1'b0;  up_f = 1'b0;
      end else begin
         mode_f = m;  up_f = u;  mode_s = 1'b0;  up_s = 1'b0;
      end
   endtask

   // Expectation for the outputs right after the edge driven by the last step.
   task automatic expect_next(input string tag, input logic [28:0] v);
      exp_q.push_back(v);
      tgt_q.push_back(cyc + 1);
      sel_q.push_back(sel);
      tag_q.push_back(tag);
   endtask

   task automatic drive(input logic m, input logic u, input string tag, input logic [28:0] v);
      step(m, u);
      expect_next(tag, v);
   endtask

   // The edge driven by the most recent step becomes relative edge 1.
   task automatic mark_rel();
      rel_cyc = cyc;
   endtask

   task automatic run_to(input int k, input string tag, input logic [28:0] v);
      do begin
         step(1'b0, 1'b0);
      end while (cyc + 1 - rel_cyc < k);
      expect_next(tag, v);
   endtask

   task automatic up_n(input int n);
      repeat (n) step(1'b0, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset values and the first second after release.
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      expect_next("reset", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      step(1'b0, 1'b0);
      rst_s = 1'b0;
      mark_rel();
      expect_next("release_e1", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      run_to(499,  "blink_on_499",  mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      run_to(500,  "blink_off_500", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      run_to(999,  "sec00_999",     mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
      run_to(1000, "sec01_1000",    mk(S_RUN, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1));

      // UP in RUN is ignored.
      drive(1'b0, 1'b1, "up_in_run_a", mk(S_RUN, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1));
      drive(1'b0, 1'b1, "up_in_run_b", mk(S_RUN, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1));

      // MODE and UP together: mode wins, hour untouched.
      drive(1'b1, 1'b1, "mode_up_same", mk(S_SH, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1));

      // 25 x UP in SET_HOUR: 23, wrap to 00, then 01.
      up_n(22);
      drive(1'b0, 1'b1, "hour_23",   mk(S_SH, 8'h23, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1));
      drive(1'b0, 1'b1, "hour_wrap", mk(S_SH, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1));
      drive(1'b0, 1'b1, "hour_01",   mk(S_SH, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1));

      // 61 x UP in SET_MIN: 59, wrap to 00 without touching hours, then 01.
      drive(1'b1, 1'b0, "enter_set_min", mk(S_SM, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1));
      up_n(58);
      drive(1'b0, 1'b1, "min_59",   mk(S_SM, 8'h01, 8'h59, 8'h01, 1'b0, 1'b1, 1'b1));
      drive(1'b0, 1'b1, "min_wrap", mk(S_SM, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1));
      drive(1'b0, 1'b1, "min_01",   mk(S_SM, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1));

      // Exit to RUN clears seconds and restarts the prescaler.
      drive(1'b1, 1'b0, "exit_to_run", mk(S_RUN, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1));
      mark_rel();
      run_to(1000, "restart_999",  mk(S_RUN, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0));
      run_to(1001, "restart_1000", mk(S_RUN, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1));

      // Reset in SET_MIN with UP high: reset wins, no increment.
      drive(1'b1, 1'b0, "to_set_hour", mk(S_SH, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1));
      drive(1'b1, 1'b0, "to_set_min",  mk(S_SM, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1));
      step(1'b0, 1'b1);
      rst_s = 1'b1;
      expect_next("rst_mid_set", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      step(1'b0, 1'b0);
      rst_s = 1'b0;
      expect_next("after_rst", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));

      // Rollover on the fast instance (4 ticks/s, blink period 4).
      sel = 1'b1;
      step(1'b0, 1'b0);
      expect_next("f_reset", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      step(1'b0, 1'b0);
      rst_f = 1'b0;
      drive(1'b1, 1'b0, "f_set_hour", mk(S_SH, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1));
      up_n(22);
      drive(1'b0, 1'b1, "f_hour_23", mk(S_SH, 8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
      drive(1'b1, 1'b0, "f_set_min", mk(S_SM, 8'h23, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1));
      up_n(58);
      drive(1'b0, 1'b1, "f_min_59", mk(S_SM, 8'h23, 8'h59, 8'h00, 1'b0, 1'b1, 1'b0));
      drive(1'b1, 1'b0, "f_exit",   mk(S_RUN, 8'h23, 8'h59, 8'h00, 1'b0, 1'b0, 1'b1));
      mark_rel();
      run_to(240, "f_pre_roll",  mk(S_RUN, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0));
      run_to(241, "f_rollover",  mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
      run_to(242, "f_post_roll", mk(S_RUN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1));

      // Drain: every expectation must have been consumed.
      step(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (tgt_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", tgt_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
